dot_accum: RTL and testbench
============================

// Module: dot_accum
// PURPOSE
//  Downstream consumer of the pipelined 6x6 multiplier's 12-bit product stream.
//  Sums a frame of products, terminated by in_last, into one dot-product result.
//  Presents the result with a valid/ready handshake to the next stage.
//  The upstream pipeline cannot stall, so the block flags products it has to drop.
// PARAMETERS
//  PW     12  product width (matches multiplier result)
//  ACC_W  20  accumulator / out_sum width; must be >= PW
//  LEN_W  4   frame-length counter width; max frame = 2**LEN_W-1 products
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_data carries a product this cycle
//  in_data    in   PW     unsigned product
//  in_last    in   1      final product of the frame (qualified by in_valid)
//  out_valid  out  1      out_sum/out_count/ovf/trunc valid
//  out_ready  in   1      consumer accepts result when out_valid && out_ready
//  out_sum    out  ACC_W  frame sum
//  out_count  out  LEN_W  number of products in the frame
//  ovf        out  1      sum exceeded 2**ACC_W-1 during the frame
//  trunc      out  1      frame closed by length limit, not by in_last
//  drop       out  1      sticky: a product arrived in HOLD and was lost
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; acc, cnt, out_valid, ovf, trunc, drop, busy = 0.
//  FSM states: IDLE, ACCUM, HOLD. out_valid = (state==HOLD), driven from a register.
//  IDLE: on in_valid, acc<=in_data and cnt<=1; go to HOLD if in_last, else ACCUM.
//  ACCUM: on in_valid, acc<=acc+in_data and cnt<=cnt+1.
//   - in_last -> HOLD.
//   - cnt reaching 2**LEN_W-1 without in_last -> HOLD with trunc=1.
//   - No in_valid: hold all state; idle gaps inside a frame are legal.
//  Latency: result visible the cycle after the product carrying in_last is sampled.
//  HOLD: out_sum, out_count, ovf and trunc stay stable until handshake.
//   - out_ready -> IDLE.
//   - out_ready && in_valid in the same cycle: the product starts a new frame.
//     Apply the IDLE rules to it directly (back-to-back frames, no bubble).
//   - in_valid && !out_ready: product discarded, drop<=1.
//  drop clears only on rst.
//  ovf: set when the true ACC_W+1-bit sum carries out. Cleared when a new frame starts.
//  Single-product frame (in_last on the first beat): out_count=1, out_sum=in_data.
//  in_last with in_valid=0 is ignored.
//  rst mid-frame discards the partial sum; no output is produced for that frame.
// CONFIGURATION
//  DOT_ACCUM_SAT_EN defined: on carry-out, acc clamps to 2**ACC_W-1 and stays
//   clamped for the rest of the frame; ovf=1.
//  Not defined: acc wraps modulo 2**ACC_W; ovf=1 still reported.
// STRUCTURE
//  Shared package/header: FSM state encodings, PW default (12), ACC_W/LEN_W defaults.
//  One natural sub-module: dot_accum_add (ACC_W adder with carry-out and
//   optional saturation). FSM and output registers stay in dot_accum.
// TESTING
//  Products 10,20,30, last on 30 -> out_valid, out_sum=60, out_count=3, ovf=0.
//  Frame 5(last) then 7(last) on the next cycle, out_ready=1 -> sums 5 then 7,
//   no bubble cycles, drop=0.
//  out_ready=0 for 4 cycles in HOLD with in_valid=1 -> out_sum held, drop=1 sticky.
//  ACC_W=12: 4095 then 1 (last) -> ovf=1; out_sum=0 (wrap) or 4095 (SAT_EN).
//  15 products without in_last (LEN_W=4) -> HOLD, trunc=1, out_count=15.
//  rst asserted after 2 products of a frame -> IDLE, out_valid=0, next frame sums from 0.

Source files
------------

// File: rtl/dot_accum_pkg.sv
// Shared definitions for the dot-product accumulator: FSM state encoding and
// default widths.
//   PW_DEF     product width delivered by the 6x6 multiplier
//   ACC_W_DEF  accumulator / result width
//   LEN_W_DEF  frame-length counter width
package dot_accum_pkg;

  localparam int unsigned PW_DEF    = 12;
  localparam int unsigned ACC_W_DEF = 20;
  localparam int unsigned LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/dot_accum_add.sv
// ACC_W-bit accumulate adder with carry-out.
// With DOT_ACCUM_SAT_EN defined the sum clamps to all-ones on carry-out,
// otherwise it wraps modulo 2**ACC_W.
//   acc     current accumulator value
//   addend  unsigned product to add
//   sum_c   next accumulator value (combinational)
//   carry_c true ACC_W+1-bit sum carried out (combinational)
module dot_accum_add
  import dot_accum_pkg::*;
#(
  parameter int unsigned PW    = PW_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [PW-1:0]    addend,
  output logic [ACC_W-1:0] sum_c,
  output logic             carry_c
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] full_c;

  always_comb begin
    full_c  = {1'b0, acc} + SUM_W'(addend);
    carry_c = full_c[ACC_W];
`ifdef DOT_ACCUM_SAT_EN
    // Once clamped, further adds carry again, so the sum stays at all-ones.
    sum_c   = carry_c ? {ACC_W{1'b1}} : full_c[ACC_W-1:0];
`else
    sum_c   = full_c[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/dot_accum.sv
// Frame accumulator for the multiplier product stream. Sums products until
// in_last (or the length limit), then holds the result under a valid/ready
// handshake. Products arriving while a result is stalled are dropped and
// flagged. Optional macro DOT_ACCUM_SAT_EN selects saturating accumulation.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_data/in_last   product stream (cannot be stalled)
//   out_valid/out_ready   result handshake
//   out_sum/out_count     frame sum and number of products
//   ovf, trunc            frame overflowed / closed by length limit
//   drop                  sticky: a product was lost while holding
//   busy                  not idle
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int unsigned PW    = PW_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PW-1:0]    in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_count,
  output logic             ovf,
  output logic             trunc,
  output logic             drop,
  output logic             busy
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] sum_c;
  logic             carry_c;
  logic [LEN_W-1:0] cnt_inc_c;

  dot_accum_add #(
    .PW    (PW),
    .ACC_W (ACC_W)
  ) u_add (
    .acc     (acc),
    .addend  (in_data),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  assign cnt_inc_c = cnt + CNT_ONE;
  assign out_sum   = acc;
  assign out_count = cnt;

  // Frame FSM and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      trunc     <= 1'b0;
      drop      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (state == ST_HOLD && !out_ready) begin
            // Result stalled: upstream cannot wait, so the product is lost.
            if (in_valid) drop <= 1'b1;
          end else if (in_valid) begin
            // New frame; in HOLD this is the back-to-back case.
            acc   <= ACC_W'(in_data);
            cnt   <= CNT_ONE;
            ovf   <= 1'b0;
            trunc <= 1'b0;
            busy  <= 1'b1;
            if (in_last || CNT_ONE == CNT_MAX) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              trunc     <= !in_last;
            end else begin
              state     <= ST_ACCUM;
              out_valid <= 1'b0;
            end
          end else begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc <= sum_c;
            cnt <= cnt_inc_c;
            if (carry_c) ovf <= 1'b1;
            if (in_last) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
            end else if (cnt_inc_c == CNT_MAX) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              trunc     <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Self-checking bench for dot_accum (ACC_W=12 so overflow is reachable).
// A frame-level reference model (product queue, integer sum) predicts outputs;
// a negedge process compares every cycle, and directed sequences pin literals.
module tb_dot_accum;

  localparam int unsigned PW     = 12;
  localparam int unsigned ACC_W  = 12;
  localparam int unsigned LEN_W  = 4;
  localparam int          MAXLEN = 15;
  localparam int          AMAX   = 4095;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [PW-1:0]    in_data = '0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_count;
  logic             ovf, trunc, drop, busy;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int m_frame[$];
  bit m_hold = 1'b0;
  int m_sum = 0, m_cnt = 0;
  bit m_ovf = 1'b0, m_trunc = 1'b0, m_drop = 1'b0;

  dot_accum #(.PW(PW), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .ovf(ovf), .trunc(trunc),
    .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Close a frame: sum is the plain integer total, wrapped or clamped.
  task automatic model_close(input bit tr);
    int total = 0;
    foreach (m_frame[i]) total += m_frame[i];
    m_cnt = m_frame.size();
    m_ovf = (total > AMAX);
`ifdef DOT_ACCUM_SAT_EN
    m_sum = (total > AMAX) ? AMAX : total;
`else
    m_sum = total % (AMAX + 1);
`endif
    m_trunc = tr;
    m_hold  = 1'b1;
    m_frame.delete();
  endtask

  task automatic model_feed(input int d, input bit l);
    m_frame.push_back(d);
    if (l) model_close(1'b0);
    else if (m_frame.size() == MAXLEN) model_close(1'b1);
  endtask

  task automatic model_step();
    if (rst) begin
      m_frame.delete();
      m_hold = 1'b0; m_drop = 1'b0; m_ovf = 1'b0; m_trunc = 1'b0;
      m_sum = 0; m_cnt = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        if (in_valid) model_feed(int'(in_data), in_last);
      end else if (in_valid) begin
        m_drop = 1'b1;
      end
    end else if (in_valid) begin
      model_feed(int'(in_data), in_last);
    end
  endtask

  // One clock: inputs already driven; model follows the same edge.
  task automatic cyc(input bit v, input int d, input bit l, input bit r);
    in_valid  = v;
    in_data   = PW'(d);
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(m_hold));
      check("busy", 32'(busy), 32'(m_hold || m_frame.size() != 0));
      check("drop", 32'(drop), 32'(m_drop));
      if (m_hold) begin
        check("out_sum", 32'(out_sum), 32'(m_sum));
        check("out_count", 32'(out_count), 32'(m_cnt));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("trunc", 32'(trunc), 32'(m_trunc));
      end
    end
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(out_sum), 0);
    check("rst_count", 32'(out_count), 0);
    check("rst_flags", {28'd0, ovf, trunc, drop, busy}, 0);

    // 10,20,30 -> 60
    cyc(1'b1, 10, 1'b0, 1'b0);
    cyc(1'b1, 20, 1'b0, 1'b0);
    cyc(1'b1, 30, 1'b1, 1'b0);
    check("lit_valid60", 32'(out_valid), 1);
    check("lit_sum60", 32'(out_sum), 60);
    check("lit_cnt3", 32'(out_count), 3);
    check("lit_ovf60", 32'(ovf), 0);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Back-to-back single-product frames
    cyc(1'b1, 5, 1'b1, 1'b1);
    check("lit_b2b_5", 32'(out_sum), 5);
    cyc(1'b1, 7, 1'b1, 1'b1);
    check("lit_b2b_valid", 32'(out_valid), 1);
    check("lit_b2b_7", 32'(out_sum), 7);
    check("lit_b2b_cnt", 32'(out_count), 1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("lit_b2b_drop", 32'(drop), 0);

    // Overflow at ACC_W=12
    cyc(1'b1, 4095, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b1, 1'b0);
    check("lit_ovf", 32'(ovf), 1);
`ifdef DOT_ACCUM_SAT_EN
    check("lit_ovf_sum", 32'(out_sum), 4095);
`else
    check("lit_ovf_sum", 32'(out_sum), 0);
`endif
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Length-limit truncation: 1..15 sums to 120
    for (int i = 1; i <= MAXLEN; i++) cyc(1'b1, i, 1'b0, 1'b0);
    check("lit_trunc", 32'(trunc), 1);
    check("lit_trunc_cnt", 32'(out_count), 15);
    check("lit_trunc_sum", 32'(out_sum), 120);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Stalled result with products arriving
    cyc(1'b1, 9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, int'($urandom_range(0, 4095)), 1'b0, 1'b0);
    check("lit_hold_sum", 32'(out_sum), 9);
    check("lit_drop", 32'(drop), 1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("lit_drop_sticky", 32'(drop), 1);

    // Reset mid-frame
    cyc(1'b1, 3, 1'b0, 1'b0);
    cyc(1'b1, 4, 1'b0, 1'b0);
    do_reset();
    check("lit_rst_valid", 32'(out_valid), 0);
    check("lit_rst_busy", 32'(busy), 0);
    check("lit_rst_drop", 32'(drop), 0);
    cyc(1'b1, 6, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b1, 1'b0);
    check("lit_rst_sum", 32'(out_sum), 7);
    check("lit_rst_cnt", 32'(out_count), 2);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) < 7,
            ($urandom_range(0, 3) == 0) ? 4095 : int'($urandom_range(0, 4095)),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
